// File: rtl/seq_scan_ctrl.sv
// Word-to-bit stream controller for the serial 1011 detector: serializes words
// MSB-first, holds the detector in reset when idle or stalled, counts its hits.
module seq_scan_ctrl #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              word_valid,
   output logic              word_ready,
   input  logic [DATA_W-1:0] word_data,
   input  logic              word_last,
   output logic              det_bit,
   output logic              det_rst,
   input  logic              det_seen,
   output logic [CNT_W-1:0]  match_count,
   output logic              overflow,
   output logic              busy,
   output logic              done
);

   localparam int               IDX_W    = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_SHIFT = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_r;
   state_t            state_s;
   logic [DATA_W-1:0] shift_r;
   logic [IDX_W-1:0]  idx_r;
   logic              last_r;
   logic [CNT_W-1:0]  count_r;
   logic              overflow_r;
   logic              bit_end_s;
   logic              accept_s;
   logic              count_en_s;

   // Output and handshake decode from the registered state
   always_comb begin
      bit_end_s  = (state_r == S_SHIFT) && (idx_r == IDX_LAST);
      word_ready = (state_r == S_WAIT) || (bit_end_s && !last_r);
      accept_s   = word_ready && word_valid;
      det_rst    = !((state_r == S_SHIFT) || (state_r == S_DRAIN));
      det_bit    = (state_r == S_SHIFT) ? shift_r[DATA_W-1] : 1'b0;
      busy       = (state_r != S_IDLE);
      done       = (state_r == S_DONE);
      // A hit registered for the previous bit is still valid in WAIT and DRAIN
      count_en_s = det_seen && ((state_r == S_WAIT) || (state_r == S_SHIFT) ||
                                (state_r == S_DRAIN));
   end

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) state_s = S_WAIT;
            else       state_s = S_IDLE;
         end
         S_WAIT: begin
            if (word_valid) state_s = S_SHIFT;
            else            state_s = S_WAIT;
         end
         S_SHIFT: begin
            if (!bit_end_s)    state_s = S_SHIFT;
            else if (accept_s) state_s = S_SHIFT;
            else if (last_r)   state_s = S_DRAIN;
            else               state_s = S_WAIT;
         end
         S_DRAIN: state_s = S_DONE;
         S_DONE:  state_s = S_IDLE;
         default: state_s = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_r <= S_IDLE;
      else       state_r <= state_s;
   end

   // Shift register, bit index and last-word flag
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_r <= {DATA_W{1'b0}};
         idx_r   <= {IDX_W{1'b0}};
         last_r  <= 1'b0;
      end else if (accept_s) begin
         shift_r <= word_data;
         idx_r   <= {IDX_W{1'b0}};
         last_r  <= word_last;
      end else if (state_r == S_SHIFT) begin
         shift_r <= {shift_r[DATA_W-2:0], 1'b0};
         idx_r   <= idx_r + IDX_W'(1);
      end else begin
         shift_r <= shift_r;
         idx_r   <= idx_r;
         last_r  <= last_r;
      end
   end

   // Saturating hit counter with sticky overflow, cleared by an accepted start
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r    <= {CNT_W{1'b0}};
         overflow_r <= 1'b0;
      end else if ((state_r == S_IDLE) && start) begin
         count_r    <= {CNT_W{1'b0}};
         overflow_r <= 1'b0;
      end else if (count_en_s) begin
         if (count_r == CNT_MAX) overflow_r <= 1'b1;
         else                    count_r    <= count_r + CNT_W'(1);
      end else begin
         count_r    <= count_r;
         overflow_r <= overflow_r;
      end
   end

   assign match_count = count_r;
   assign overflow    = overflow_r;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: a 16-bit and a 2-bit counter instance share stimulus,
// each fed by its own 1011 detector, checked every cycle against a bit-queue model.
module tb_seq_scan_ctrl;

   localparam int DATA_W  = 8;
   localparam int P_IDLE  = 0;
   localparam int P_WAIT  = 1;
   localparam int P_SHIFT = 2;
   localparam int P_DRAIN = 3;
   localparam int P_DONE  = 4;

   logic        clk = 1'b0;
   logic        reset, start, word_valid, word_last;
   logic [7:0]  word_data;
   logic        word_ready_a, det_bit_a, det_rst_a, overflow_a, busy_a, done_a;
   logic        word_ready_b, det_bit_b, det_rst_b, overflow_b, busy_b, done_b;
   logic        det_seen_a = 1'b0, det_seen_b = 1'b0;
   logic [3:0]  hist_a = 4'd0, hist_b = 4'd0;
   logic [15:0] count_a;
   logic [1:0]  count_b;
   int          checks = 0, errors = 0, cyc_cnt = 0;
   bit          chk_en = 1'b0;

   always #5 clk = ~clk;

   seq_scan_ctrl #(.DATA_W(DATA_W), .CNT_W(16)) dut_a (
      .clk(clk), .reset(reset), .start(start), .word_valid(word_valid),
      .word_ready(word_ready_a), .word_data(word_data), .word_last(word_last),
      .det_bit(det_bit_a), .det_rst(det_rst_a), .det_seen(det_seen_a),
      .match_count(count_a), .overflow(overflow_a), .busy(busy_a), .done(done_a));

   seq_scan_ctrl #(.DATA_W(DATA_W), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .start(start), .word_valid(word_valid),
      .word_ready(word_ready_b), .word_data(word_data), .word_last(word_last),
      .det_bit(det_bit_b), .det_rst(det_rst_b), .det_seen(det_seen_b),
      .match_count(count_b), .overflow(overflow_b), .busy(busy_b), .done(done_b));

   // Overlapping 1011 detectors driven by each DUT, hit registered one cycle late
   always @(posedge clk) begin
      cyc_cnt <= cyc_cnt + 1;
      if (det_rst_a) begin hist_a <= 4'd0; det_seen_a <= 1'b0; end
      else begin
         hist_a     <= {hist_a[2:0], det_bit_a};
         det_seen_a <= ({hist_a[2:0], det_bit_a} == 4'b1011);
      end
      if (det_rst_b) begin hist_b <= 4'd0; det_seen_b <= 1'b0; end
      else begin
         hist_b     <= {hist_b[2:0], det_bit_b};
         det_seen_b <= ({hist_b[2:0], det_bit_b} == 4'b1011);
      end
   end

   // Reference model: phase, queue of pending bits, raw hit total
   int       m_phase = P_IDLE;
   bit       m_bits[$];
   bit       m_last = 1'b0;
   int       m_hits = 0;
   bit [3:0] m_hist = 4'd0;
   bit       m_seen = 1'b0;

   function automatic bit e_ready();
      return (m_phase == P_WAIT) ||
             (m_phase == P_SHIFT && m_bits.size() == 1 && !m_last);
   endfunction
   function automatic bit e_rst();
      return !(m_phase == P_SHIFT || m_phase == P_DRAIN);
   endfunction
   function automatic bit e_bit();
      return (m_phase == P_SHIFT) ? m_bits[0] : 1'b0;
   endfunction
   function automatic void load_word();
      m_bits.delete();
      for (int i = DATA_W - 1; i >= 0; i--) m_bits.push_back(word_data[i]);
      m_last = word_last;
   endfunction

   always @(posedge clk) begin : model
      bit rdy, rst_e, b;
      rdy   = e_ready();
      rst_e = e_rst();
      b     = e_bit();
      if (reset) begin
         m_phase = P_IDLE; m_bits.delete(); m_last = 1'b0;
         m_hits = 0; m_hist = 4'd0; m_seen = 1'b0;
      end else begin
         if (m_seen && (m_phase == P_WAIT || m_phase == P_SHIFT || m_phase == P_DRAIN))
            m_hits++;
         if (rst_e) begin m_hist = 4'd0; m_seen = 1'b0; end
         else begin m_hist = {m_hist[2:0], b}; m_seen = (m_hist == 4'b1011); end
         case (m_phase)
            P_IDLE:  if (start) begin m_hits = 0; m_phase = P_WAIT; end
            P_WAIT:  if (word_valid) begin load_word(); m_phase = P_SHIFT; end
            P_SHIFT: begin
               void'(m_bits.pop_front());
               if (m_bits.size() == 0) begin
                  if (word_valid && rdy) load_word();
                  else m_phase = m_last ? P_DRAIN : P_WAIT;
               end
            end
            P_DRAIN: m_phase = P_DONE;
            default: m_phase = P_IDLE;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison of both DUTs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy_a",  busy_a,       m_phase != P_IDLE);
         chk("done_a",  done_a,       m_phase == P_DONE);
         chk("ready_a", word_ready_a, e_ready());
         chk("drst_a",  det_rst_a,    e_rst());
         chk("dbit_a",  det_bit_a,    e_bit());
         chk("cnt_a",   count_a,      (m_hits > 65535) ? 65535 : m_hits);
         chk("ovf_a",   overflow_a,   m_hits > 65535);
         chk("busy_b",  busy_b,       m_phase != P_IDLE);
         chk("done_b",  done_b,       m_phase == P_DONE);
         chk("ready_b", word_ready_b, e_ready());
         chk("drst_b",  det_rst_b,    e_rst());
         chk("dbit_b",  det_bit_b,    e_bit());
         chk("cnt_b",   count_b,      (m_hits > 3) ? 3 : m_hits);
         chk("ovf_b",   overflow_b,   m_hits > 3);
      end
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic do_start();
      start = 1'b1; cyc(); start = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] d, input logic l, output int hs);
      bit acc; int n;
      acc = 1'b0; n = 0; hs = 0;
      word_data = d; word_last = l; word_valid = 1'b1;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = word_ready_a; hs = cyc_cnt; n++;
         @(posedge clk); #1;
      end
      if (!acc) chk("handshake_timeout", 0, 1);
      word_valid = 1'b0;
   endtask

   // Returns at the negedge of the done cycle
   task automatic wait_done(input string name, input int hs, input logic [15:0] ea,
                            input logic [1:0] eb, input logic eovb);
      bit got; int n;
      got = 1'b0; n = 0;
      while (!got && n < 200) begin
         @(negedge clk); n++;
         if (done_a) got = 1'b1;
         else begin @(posedge clk); #1; end
      end
      chk({name, "_latency"}, cyc_cnt - hs, 10);
      chk({name, "_done_b"}, done_b, 1'b1);
      chk({name, "_count_a"}, count_a, ea);
      chk({name, "_ovf_a"}, overflow_a, 1'b0);
      chk({name, "_count_b"}, count_b, eb);
      chk({name, "_ovf_b"}, overflow_b, eovb);
      chk({name, "_model_hits"}, m_hits, ea);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin : stim
      int h, h1, h2;
      logic [7:0] pat;
      reset = 1'b1; start = 1'b0; word_valid = 1'b0; word_data = 8'h00; word_last = 1'b0;
      cyc();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_ready", word_ready_a, 1'b0);
      chk("rst_det_rst", det_rst_a, 1'b1);
      chk("rst_count", count_a, 16'd0);
      chk("rst_done", done_a, 1'b0);
      cyc(); reset = 1'b0; cyc();

      // Single word 0xB0: bits 1,0,1,1,0,0,0,0 and one hit
      do_start();
      pat = 8'hB0;
      send_word(pat, 1'b1, h);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("single_bit", det_bit_a, pat[7-i]);
         @(posedge clk); #1;
      end
      wait_done("single", h, 16'd1, 2'd1, 1'b0);
      cyc();

      // Back-to-back 0xB6, 0xC0 with zero bubble and overlapping hits
      do_start();
      send_word(8'hB6, 1'b0, h1);
      send_word(8'hC0, 1'b1, h2);
      chk("b2b_gap", h2 - h1, 8);
      wait_done("b2b", h2, 16'd3, 2'd3, 1'b0);
      cyc();

      // Stall between 0x05 and 0x80 resets the detector
      do_start();
      send_word(8'h05, 1'b0, h1);
      repeat (8) cyc();
      repeat (3) begin
         @(negedge clk);
         chk("stall_det_rst", det_rst_a, 1'b1);
         @(posedge clk); #1;
      end
      send_word(8'h80, 1'b1, h2);
      wait_done("stall", h2, 16'd0, 2'd0, 1'b0);
      cyc();

      // Saturation: three 0xBB words give 6 hits
      do_start();
      send_word(8'hBB, 1'b0, h);
      send_word(8'hBB, 1'b0, h);
      send_word(8'hBB, 1'b1, h);
      wait_done("sat", h, 16'd6, 2'd3, 1'b1);
      cyc();
      repeat (3) begin
         @(negedge clk);
         chk("sat_hold_cnt", count_b, 2'd3);
         chk("sat_hold_ovf", overflow_b, 1'b1);
         @(posedge clk); #1;
      end
      do_start();
      @(negedge clk);
      chk("sat_clear_cnt", count_b, 2'd0);
      chk("sat_clear_ovf", overflow_b, 1'b0);
      chk("sat_clear_cnt_a", count_a, 16'd0);
      @(posedge clk); #1;

      // Reset during bit index 4 of 0xB0, just as its hit would be counted
      send_word(8'hB0, 1'b1, h);
      repeat (4) cyc();
      reset = 1'b1; cyc(); reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", busy_a, 1'b0);
      chk("mid_rst_ready", word_ready_a, 1'b0);
      chk("mid_rst_det_rst", det_rst_a, 1'b1);
      chk("mid_rst_count", count_a, 16'd0);
      chk("mid_rst_done", done_a, 1'b0);
      @(posedge clk); #1;
      do_start();
      send_word(8'hB0, 1'b1, h);
      wait_done("after_rst", h, 16'd1, 2'd1, 1'b0);
      cyc();

      // Start pulses during SHIFT and DONE are ignored
      do_start();
      send_word(8'hBB, 1'b1, h);
      repeat (6) cyc();
      start = 1'b1; cyc(); start = 1'b0;
      @(negedge clk);
      chk("shift_start_busy", busy_a, 1'b1);
      chk("shift_start_cnt", count_a, 16'd1);
      wait_done("ign_start", h, 16'd2, 2'd2, 1'b0);
      start = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_start_busy", busy_a, 1'b0);
      chk("done_start_cnt", count_a, 16'd2);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("idle_start_busy", busy_a, 1'b1);
      chk("idle_start_ready", word_ready_a, 1'b1);
      chk("idle_start_cnt", count_a, 16'd0);
      @(posedge clk); #1;
      // 0x0B completes its hit on the final bit, captured in DRAIN
      send_word(8'h0B, 1'b1, h);
      wait_done("drain_hit", h, 16'd1, 2'd1, 1'b0);
      cyc();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Stream controller that owns and sequences one instance of the team's serial 1011 sequence detector. It accepts DATA_W-bit words over a valid/ready handshake and serializes them MSB-first onto the detector's bit input, with no gaps between back-to-back words. It holds the detector in reset whenever the stream stalls or is idle, and counts detector hits into a saturating match counter. It sits between a word-oriented producer and the bit-serial detector and reports a per-frame count on `done`.

## Interface
- `DATA_W`, default 8: word width, ≥2.
- `CNT_W`, default 16: match counter width, ≥1.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high; clock `clk`.
- `start` in 1: single-cycle pulse that begins a frame; ignored unless in IDLE.
- `word_valid` in 1: producer word valid.
- `word_ready` out 1: controller can accept a word.
- `word_data` in DATA_W: word, sent MSB first.
- `word_last` in 1: marks the final word of the frame; sampled with the handshake.
- `det_bit` out 1: serial bit to the detector.
- `det_rst` out 1: synchronous reset to the detector.
- `det_seen` in 1: detector hit; registered in the detector, one cycle after the completing bit.
- `match_count` out CNT_W: saturating hit count for the current or last frame.
- `overflow` out 1: sticky; set when a hit arrives with the counter at all-ones.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `match_count` is final in that cycle.

## Operation
- States: IDLE, WAIT, SHIFT, DRAIN, DONE.
- **IDLE**
  - `det_rst`=1, `det_bit`=0, `word_ready`=0.
  - On `start`: clear `match_count` and `overflow`, go to WAIT.
- **WAIT**
  - `word_ready`=1, `det_rst`=1, `det_bit`=0.
  - On `word_valid`: load the shift register and the `last` flag, go to SHIFT with bit index 0.
- **SHIFT**
  - `det_rst`=0; `det_bit` = shift-register MSB; shift left each cycle.
  - Lasts DATA_W cycles per word.
  - In the bit-index DATA_W-1 cycle only, `word_ready` = !`last`.
  - If a word is accepted in that cycle: reload and stay in SHIFT at index 0, with zero bubble.
  - Otherwise: go to DRAIN if `last` is set, else to WAIT. WAIT holds the detector in reset, so a stall breaks any partial pattern.
- **DRAIN**
  - One cycle; `det_rst`=0, `det_bit`=0.
  - Captures `det_seen` for the final bit.
- **DONE**
  - One cycle; `done`=1, then go to IDLE.
- **Counting**
  - In WAIT, SHIFT and DRAIN, each cycle with `det_seen`=1 increments `match_count` at the clock edge.
  - At all-ones the counter holds and `overflow` is set.
  - `det_seen` is ignored in IDLE and DONE.
  - `match_count`/`overflow` hold after DONE until the next accepted `start`.
- **Other rules**
  - `start` outside IDLE has no effect.
  - `word_valid` is ignored whenever `word_ready`=0.
  - Producer rule: `word_data`/`word_last` are stable while `word_valid`=1 and `word_ready`=0.

## Timing
- Reset values:
  - state IDLE; `match_count`=0, `overflow`=0, `busy`=0, `done`=0.
  - `word_ready`=0, `det_bit`=0, `det_rst`=1.
- `start` at cycle t: WAIT at t+1, where `word_ready`=1.
- Handshake at t: bit i of the word is on `det_bit` in cycle t+1+i.
- Last bit of the final word at cycle s: DRAIN at s+1, DONE (`done`=1, final count) at s+2, IDLE at s+3.
- Hit timing: `det_seen` for the bit driven in cycle c is counted at the end of cycle c+1 and visible on `match_count` at c+2.
- Reset asserted mid-frame takes effect at the next edge:
  - all outputs return to reset values; any in-flight word is dropped.
  - `det_rst` is 1 combinationally from the decoded IDLE state.

## Test plan
- **Single word.** CNT_W=16. Start, then one word 0xB0 with `word_last`=1, valid immediately.
  - `det_bit` sequence 1,0,1,1,0,0,0,0.
  - `done` pulse with `match_count`=1 exactly 10 cycles after the handshake.
  - `overflow`=0.
- **Back-to-back with overlap.** Words 0xB6 then 0xC0 (`last`), second offered during the first word's index-7 cycle.
  - Zero bubble; 16 contiguous SHIFT cycles.
  - `match_count`=3 at `done`.
- **Stall breaks the pattern.** Word 0x05 (not last), `word_valid` low for 3 cycles, then 0x80 (last).
  - `det_rst`=1 during the gap.
  - `match_count`=0 (with no stall the result would be 1).
- **Saturation.** CNT_W=2, three words 0xBB (last on the third), continuous.
  - 6 hits: `match_count` saturates at 3 and `overflow`=1 at `done`.
  - Both hold through IDLE; the next `start` clears them.
- **Reset mid-frame.** Assert `reset` during bit index 4 of word 0xB0.
  - Next cycle: `busy`=0, `word_ready`=0, `det_rst`=1, `match_count`=0, no `done`.
  - A new frame afterwards behaves as in the single-word test.
- **Ignored start.** `start` pulsed during SHIFT and during DONE.
  - No state change, no count clear.
  - `start` one cycle after `done` (in IDLE) begins a new frame normally.
